// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin selector arbiter: state encoding,
// requester count/index width and the default burst length.
package arbitro_pkg;

    localparam int NUM_REQ       = 4;
    localparam int SEL_W         = 2;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arbitro_selector_rr_buscar.sv
// Combinational first-set-bit search over a masked request vector, starting at
// a given index and wrapping modulo NUM_REQ.
module rr_buscar
    import arbitro_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   offset;

    assign masked = req & mask;

    // rot[0] is the candidate at 'start', rot[1] the next one, and so on
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = masked[start + SEL_W'(gi)];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = SEL_W'(i);
            end
        end
    end

    assign idx = start + offset;

endmodule

// File: rtl/arbitro_selector.sv
// Round-robin burst arbiter driving a registered 4:1 bit-select mux.
// Optional ARBITRO_PRIO0_EN gives requester 0 absolute priority at arbitration points.
module arbitro_selector
    import arbitro_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CNT_W     = 4
) (
    input  logic               iClock,
    input  logic               iReset_n,
    input  logic [NUM_REQ-1:0] iReq,
    output logic [NUM_REQ-1:0] oGrant,
    output logic [SEL_W-1:0]   oSelector,
    output logic               oBusy,
    output logic               oValid,
    output logic [SEL_W-1:0]   oOwner
);

    state_t             state_reg,    state_next;
    logic [CNT_W-1:0]   counter_reg,  counter_next;
    logic [SEL_W-1:0]   last_reg,     last_next;
    logic [NUM_REQ-1:0] grant_reg,    grant_next;
    logic [SEL_W-1:0]   selector_reg, selector_next;
    logic               busy_reg;
    logic               valid_reg;
    logic [SEL_W-1:0]   owner_reg;

    logic               burst_end;
    logic               prio_win;
    logic [NUM_REQ-1:0] search_mask;
    logic               found;
    logic [SEL_W-1:0]   found_idx;

    // The current owner is excluded while granted so a burst end always looks elsewhere first
    assign search_mask = (state_reg == ST_GRANT) ? ~onehot(selector_reg) : '1;

    rr_buscar u_buscar (
        .req   (iReq),
        .mask  (search_mask),
        .start (last_reg + SEL_W'(1)),
        .found (found),
        .idx   (found_idx)
    );

`ifdef ARBITRO_PRIO0_EN
    assign prio_win = iReq[0] && !((state_reg == ST_GRANT) && (selector_reg == '0));
`else
    assign prio_win = 1'b0;
`endif

    assign burst_end = (counter_reg == CNT_W'(BURST_LEN - 1)) || !iReq[selector_reg];

    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        last_next     = last_reg;
        grant_next    = grant_reg;
        selector_next = selector_reg;
        case (state_reg)
            ST_IDLE: begin
                if (prio_win) begin
                    state_next    = ST_GRANT;
                    grant_next    = onehot('0);
                    selector_next = '0;
                    counter_next  = '0;
                end else if (found) begin
                    state_next    = ST_GRANT;
                    grant_next    = onehot(found_idx);
                    selector_next = found_idx;
                    counter_next  = '0;
                    last_next     = found_idx;
                end
            end
            ST_GRANT: begin
                if (!burst_end) begin
                    counter_next = counter_reg + CNT_W'(1);
                end else if (prio_win) begin
                    grant_next    = onehot('0);
                    selector_next = '0;
                    counter_next  = '0;
                end else if (found) begin
                    grant_next    = onehot(found_idx);
                    selector_next = found_idx;
                    counter_next  = '0;
                    last_next     = found_idx;
                end else if (iReq[selector_reg]) begin
                    counter_next = '0;
                end else begin
                    state_next   = ST_IDLE;
                    grant_next   = '0;
                    counter_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state_reg    <= ST_IDLE;
            counter_reg  <= '0;
            last_reg     <= SEL_W'(NUM_REQ - 1);
            grant_reg    <= '0;
            selector_reg <= '0;
            busy_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            owner_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            last_reg     <= last_next;
            grant_reg    <= grant_next;
            selector_reg <= selector_next;
            busy_reg     <= |grant_next;
            // Delayed copies line up with the data the mux registers one edge later
            valid_reg    <= busy_reg;
            owner_reg    <= selector_reg;
        end
    end

    assign oGrant    = grant_reg;
    assign oSelector = selector_reg;
    assign oBusy     = busy_reg;
    assign oValid    = valid_reg;
    assign oOwner    = owner_reg;

endmodule

// File: tb/tb_arbitro_selector.sv
// Table-driven bench for arbitro_selector: each row is applied for one edge and
// its expected registered outputs are queued, then popped and compared after the edge.
module tb_arbitro_selector;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       valid;
    logic [1:0] owner;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       valid;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    arbitro_selector #(.BURST_LEN(4), .CNT_W(4)) dut (
        .iClock    (clk),
        .iReset_n  (rst_n),
        .iReq      (req),
        .oGrant    (grant),
        .oSelector (sel),
        .oBusy     (busy),
        .oValid    (valid),
        .oOwner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [1:0] s, input logic b, input logic v,
                                input logic [1:0] o);
        vec_t x;
        x.rst_n = r; x.req = q; x.grant = g; x.sel = s;
        x.busy = b; x.valid = v; x.owner = o;
        vecs.push_back(x);
    endfunction

    function automatic void add_rst(input logic [3:0] q);
        add(1'b0, q, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    endfunction

    function automatic void check(input string name, input int row,
                                  input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%b expected=%b", name, row, act, exp);
        end
    endfunction

    initial begin
        int seq[4];
        int s_cur;
        int s_prev;
        vec_t e;

        rst_n = 1'b0;
        req   = 4'b0000;

        // Reset held with all requests, then continuous round-robin traffic
        add_rst(4'b1111); add_rst(4'b1111); add_rst(4'b1111);
`ifdef ARBITRO_PRIO0_EN
        seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 3;
        for (int k = 1; k <= 20; k++) begin
            s_cur  = seq[((k - 1) / 4) % 4];
            s_prev = (k > 1) ? seq[((k - 2) / 4) % 4] : 0;
            add(1'b1, 4'b1011, 4'(1 << s_cur), 2'(s_cur), 1'b1, k > 1, 2'(s_prev));
        end
`else
        for (int k = 1; k <= 20; k++) begin
            s_cur  = ((k - 1) / 4) % 4;
            s_prev = (k > 1) ? ((k - 2) / 4) % 4 : 0;
            add(1'b1, 4'b1111, 4'(1 << s_cur), 2'(s_cur), 1'b1, k > 1, 2'(s_prev));
        end
`endif

        // Early release by a lone requester 2
        add_rst(4'b0000);
        add(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd2);
        add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 2'd2);
        add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

        // Sole requester 1 across burst expiry, then release
        add_rst(4'b0000);
        for (int k = 1; k <= 10; k++)
            add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, k > 1, 2'd1);
        add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 2'd1);
        add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

        // Reset in the 2nd cycle of requester 1's burst
        add_rst(4'b0000);
        add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1);
        add_rst(4'b1111);
        add(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0);

        // Early release hands over directly with no idle bubble
        add_rst(4'b0000);
        add(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd0);
        add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1);
        add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 2'd1);
        add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("grant", i, grant, e.grant);
            check("busy",  i, {3'b000, busy},  {3'b000, e.busy});
            check("valid", i, {3'b000, valid}, {3'b000, e.valid});
            if (e.busy || !e.rst_n)
                check("selector", i, {2'b00, sel}, {2'b00, e.sel});
            if (e.valid || !e.rst_n)
                check("owner", i, {2'b00, owner}, {2'b00, e.owner});
            $display("row=%0d rst_n=%b req=%b grant=%b sel=%0d busy=%b valid=%b owner=%0d",
                     i, e.rst_n, e.req, grant, sel, busy, valid, owner);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbitro_selector.md
Name: arbitro_selector

Overview:
- Round-robin scheduler that shares the registered 4:1 bit-select datapath (selector + 4-bit data, 1-bit registered output) among four requesters.
- Each requester asserts a request. The block grants one requester at a time for a bounded burst and drives the datapath selector.
- It also produces a valid flag aligned with the datapath's registered output, one cycle after the selector.
- Sits directly upstream of the selector mux: oSelector connects to the mux selector, and each requester's data bit feeds the matching iData lane.

Parameters:
- BURST_LEN, 4, maximum consecutive granted cycles per ownership; legal range 1..16.
- CNT_W, 4, burst counter width; must satisfy 2**CNT_W >= BURST_LEN.

Ports:
- iClock  in  1  clock; all state updates on rising edge.
- iReset_n  in  1  synchronous active-low reset, sampled on the rising edge of iClock.
- iReq  in  4  request per requester; bit k = requester k.
- oGrant  out  4  one-hot grant, registered; all zero when idle.
- oSelector  out  2  binary index of the granted requester, registered; drives the mux selector.
- oBusy  out  1  registered; high while any grant is active (equals |oGrant).
- oValid  out  1  registered; oBusy delayed one cycle, aligned with the mux registered output.
- oOwner  out  2  oSelector delayed one cycle; identifies the owner of the data currently valid at the mux output.

Behaviour:
- Reset (iReset_n==0 at an edge):
  - state=IDLE, oGrant=0, oSelector=2'b00, oBusy=0, oValid=0, oOwner=2'b00.
  - Burst counter=0; round-robin pointer last=3, so the first search starts at requester 0.
  - Reset mid-burst aborts the grant immediately; no data is flagged valid after the reset edge.
- States: IDLE, GRANT.
- IDLE:
  - If iReq!=0 at an edge: the winner is the first set bit searching last+1, last+2, ... (mod 4).
  - Go to GRANT, set oGrant=onehot(winner), oSelector=winner, counter=0, last=winner.
  - If iReq==0, stay in IDLE.
- GRANT, owner w:
  - The burst ends at an edge where counter==BURST_LEN-1, or where iReq[w]==0 (early release).
  - Otherwise counter increments and the grant holds.
- Burst end:
  - Re-arbitrate in the same edge over iReq with w masked out, starting the search at w+1.
  - If another request exists, switch directly to the new winner. There is no idle bubble, counter=0, last=new winner.
  - If none exists and iReq[w] is still high (burst expired, sole requester), regrant w for a new burst with counter=0.
  - Otherwise go to IDLE and clear oGrant.
- Latency:
  - Request sampled at edge N, so oGrant/oSelector are valid in cycle N+1.
  - The mux registers the data at edge N+1; oValid/oOwner are high in cycle N+2.
- A requester may drop iReq at any time. The cycle in which the drop is sampled is still granted, and its data is flagged valid.
- Simultaneous requests are resolved purely by pointer order, so no requester waits more than 3 bursts.
- BURST_LEN==1 gives single-cycle round-robin interleaving.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because it clears on burst end.

Optional Feature:
- Macro ARBITRO_PRIO0_EN.
- Defined: requester 0 has absolute priority at every arbitration point (IDLE, and burst end). If iReq[0]==1 it wins regardless of the pointer, and last is not updated when 0 wins this way. An ongoing burst is never preempted.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package arbitro_pkg holds:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NUM_REQ=4 and SEL_W=2.
  - The default BURST_LEN.
- One natural sub-module, rr_buscar: combinational first-set-bit search. Inputs are a 4-bit request, a mask, and a 2-bit start index; outputs are found and a 2-bit index.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset: hold iReset_n=0 for 3 cycles with iReq=4'b1111 -> oGrant=0, oBusy=0, oValid=0. After release, the next edge grants requester 0 (oSelector=0).
- Round-robin, BURST_LEN=4: iReq=4'b1111 held -> owners 0,1,2,3,0, each for exactly 4 cycles, with no idle cycle between bursts. oValid stays high continuously, starting 2 cycles after the first request.
- Early release: requester 2 is alone and drops iReq in its 2nd granted cycle -> 2 granted cycles, then IDLE. oValid is high for 2 cycles, one cycle delayed, with oOwner=2.
- Sole requester with expiry: iReq=4'b0010 for 10 cycles, BURST_LEN=4 -> oGrant=4'b0010 continuously. Counter restarts at 0 every 4 cycles.
- Reset mid-burst: iReset_n=0 in the 2nd cycle of requester 1's burst -> oGrant=0 at the next edge and oValid=0 one edge later. After release, arbitration restarts from requester 0.
- ARBITRO_PRIO0_EN defined, iReq=4'b1011 -> requester 0 wins every arbitration point, so the bursts alternate 0,1,0,3,...
